// File: rtl/conv_result_collector.sv
// conv_result_collector
// Captures per-filter result write streams into one RAM per output channel,
// then drains the completed frame as a single valid/ready stream in
// pixel-major, channel-minor (HWC) order.
module conv_result_collector #(
  parameter int DATA_WIDTH            = 8,
  parameter int RESULT_W              = 6,
  parameter int RESULT_H              = 6,
  parameter int RESULT_D              = 8,
  parameter int RESULT_RAM_ADDR_WIDTH = $clog2(RESULT_W * RESULT_H),
  parameter int RESULT_D_ADDR_WIDTH   = (RESULT_D > 1) ? $clog2(RESULT_D) : 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [RESULT_RAM_ADDR_WIDTH*RESULT_D-1:0] result_wraddress,
  input  logic [DATA_WIDTH*RESULT_D-1:0]            result_data_out,
  input  logic [RESULT_D-1:0]                       result_wren,
  output logic                                      collect_rdy,
  output logic [DATA_WIDTH-1:0]                     out_data,
  output logic [RESULT_RAM_ADDR_WIDTH-1:0]          out_addr,
  output logic [RESULT_D_ADDR_WIDTH-1:0]            out_ch,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      out_last,
  output logic                                      overflow_err
);

  localparam int RAW   = RESULT_RAM_ADDR_WIDTH;
  localparam int CHW   = RESULT_D_ADDR_WIDTH;
  localparam int N     = RESULT_W * RESULT_H;
  localparam int CNT_W = RAW + 1;

  localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N);
  localparam logic [RAW-1:0]   LAST_PIX = RAW'(N - 1);
  localparam logic [CHW-1:0]   LAST_CH  = CHW'(RESULT_D - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  state_t state_reg, state_next;

  // Per-channel status and accepted/dropped write strobes
  logic [RESULT_D-1:0]   full_vec;
  logic [RESULT_D-1:0]   wr_en;
  logic [RESULT_D-1:0]   wr_drop;
  logic [DATA_WIDTH-1:0] rd_data [RESULT_D];

  // Drain read pointer and output register
  logic [RAW-1:0] pix_reg;
  logic [CHW-1:0] ch_reg;
  logic           rd_done_reg;
  logic           out_valid_reg;
  logic           out_last_reg;
  logic [RAW-1:0] out_addr_reg;
  logic [CHW-1:0] out_ch_reg;
  logic           overflow_reg;

  // Handshake / control strobes
  logic all_full;
  logic fire;
  logic last_fire;
  logic rd_en;

  genvar gi;
  generate
    for (gi = 0; gi < RESULT_D; gi++) begin : g_chan
      logic [CNT_W-1:0]      cnt_reg;
      logic [DATA_WIDTH-1:0] mem [N];
      logic [DATA_WIDTH-1:0] rd_data_reg;

      assign full_vec[gi] = (cnt_reg == N_CNT);
      // Writes land only while collecting and only until the channel holds N
      assign wr_en[gi]    = result_wren[gi] && (state_reg == COLLECT) && !full_vec[gi];
      assign wr_drop[gi]  = result_wren[gi] && !wr_en[gi];
      assign rd_data[gi]  = rd_data_reg;

      // Channel RAM write port; contents intentionally survive reset
      always_ff @(posedge clk) begin
        if (wr_en[gi]) begin
          mem[result_wraddress[gi*RAW +: RAW]] <= result_data_out[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      // Registered read port; holds its value while the output is stalled
      always_ff @(posedge clk) begin
        if (!reset) begin
          rd_data_reg <= '0;
        end else if (rd_en) begin
          rd_data_reg <= mem[pix_reg];
        end
      end

      // Per-channel write counter, cleared when the frame finishes draining
      always_ff @(posedge clk) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else if (last_fire) begin
          cnt_reg <= '0;
        end else if (wr_en[gi]) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and drain read scheduling
  always_comb begin
    state_next  = state_reg;
    collect_rdy = 1'b0;
    rd_en       = 1'b0;
    all_full    = &full_vec;
    fire        = out_valid_reg && out_ready;
    last_fire   = 1'b0;
    case (state_reg)
      COLLECT: begin
        collect_rdy = 1'b1;
        if (all_full) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Issue a read whenever the output register will be free next cycle
        rd_en     = !rd_done_reg && (!out_valid_reg || out_ready);
        last_fire = fire && out_last_reg;
        if (last_fire) begin
          state_next = COLLECT;
        end
      end
      default: begin
        state_next = COLLECT;
      end
    endcase
  end

  // Read pointer walk (channel fastest) and output register tracking the RAM read
  always_ff @(posedge clk) begin
    if (!reset) begin
      pix_reg       <= '0;
      ch_reg        <= '0;
      rd_done_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_addr_reg  <= '0;
      out_ch_reg    <= '0;
    end else if (last_fire) begin
      pix_reg       <= '0;
      ch_reg        <= '0;
      rd_done_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else if (rd_en) begin
      out_valid_reg <= 1'b1;
      out_addr_reg  <= pix_reg;
      out_ch_reg    <= ch_reg;
      out_last_reg  <= (pix_reg == LAST_PIX) && (ch_reg == LAST_CH);
      if (ch_reg == LAST_CH) begin
        ch_reg <= '0;
        if (pix_reg == LAST_PIX) begin
          rd_done_reg <= 1'b1;
        end else begin
          pix_reg <= pix_reg + RAW'(1);
        end
      end else begin
        ch_reg <= ch_reg + CHW'(1);
      end
    end else if (fire) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end
  end

  // Sticky error for any dropped write; only reset clears it
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
    end else if (|wr_drop) begin
      overflow_reg <= 1'b1;
    end
  end

  assign out_data     = rd_data[out_ch_reg];
  assign out_addr     = out_addr_reg;
  assign out_ch       = out_ch_reg;
  assign out_valid    = out_valid_reg;
  assign out_last     = out_last_reg;
  assign overflow_err = overflow_reg;

endmodule
